mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle MIPS control unit; sits directly upstream of the multi-cycle datapath.
- Consumes the latched instruction word and the ALU zero flag.
- Drives every datapath control input plus the memory read/write strobes, one FSM state per clock.
- Supports add, sub, and, or, slt, jr, lw, sw, beq, addi, slti, j, jal.

Parameters:
- ALU_AND, 3'b000, alu_ctrl code for AND
- ALU_OR, 3'b001, alu_ctrl code for OR
- ALU_ADD, 3'b010, alu_ctrl code for ADD
- ALU_SUB, 3'b110, alu_ctrl code for SUB
- ALU_SLT, 3'b111, alu_ctrl code for set-less-than

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- inst_in  input  32  instruction register contents; opcode [31:26], funct [5:0]
- zero  input  1  ALU zero flag (combinational, current cycle)
- pc_ld  output  1  PC load enable (already qualified with zero for beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- IRwrite  output  1  IR load enable
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- alu_src_A  output  1  0 = PC, 1 = A
- alu_src_B  output  2  00 = B, 01 = 4, 10 = sign-ext, 11 = sign-ext<<2
- alu_ctrl  output  3  ALU operation, codes per parameters
- reg_write  output  1  register file write enable
- pc_src  output  2  00 = ALU result, 01 = jump target, 10 = ALUOut, 11 = A
- R31_sel  output  1  force write register to 31
- jal_sel  output  1  write data = PC
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- instr_done  output  1  one-cycle pulse in the final state of each instruction

Behaviour:
- Moore FSM: outputs depend on state only, except pc_ld in BEQ (pc_ld = zero).
- Unlisted outputs are 0 in every state. alu_ctrl defaults to ALU_ADD.
- Reset: rst sampled high at a clock edge forces state to FETCH. All registered state is cleared. Reset mid-instruction aborts it with no further writes.
- FETCH:
  - IorD=0, mem_read=1, IRwrite=1, alu_src_A=0, alu_src_B=01, ADD, pc_src=00, pc_ld=1.
  - Next state: DECODE.
- DECODE:
  - alu_src_A=0, alu_src_B=11, ADD (branch target into ALUOut).
  - Dispatch on opcode:
    - 000000 with funct 001000: JR.
    - 000000 with funct 100000/100010/100100/100101/101010: R_EX.
    - 100011, 101011: MEM_ADR.
    - 000100: BEQ.
    - 001000, 001010: I_EX.
    - 000010: JUMP.
    - 000011: JAL.
    - Any other opcode or funct: FETCH, with no state writes and no instr_done.
- R_EX: alu_src_A=1, alu_src_B=00, alu_ctrl from funct (add→ADD, sub→SUB, and→AND, or→OR, slt→SLT). Next: R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
- I_EX: alu_src_A=1, alu_src_B=10; ADD for addi, SLT for slti. Next: I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
- MEM_ADR: alu_src_A=1, alu_src_B=10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, mem_read=1. Next: MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
- MEM_WR: IorD=1, mem_write=1, instr_done=1. Next: FETCH.
- BEQ: alu_src_A=1, alu_src_B=00, SUB, pc_src=10, pc_ld=zero, instr_done=1. Next: FETCH.
- JUMP: pc_src=01, pc_ld=1, instr_done=1. Next: FETCH.
- JAL:
  - pc_src=01, pc_ld=1, reg_write=1, R31_sel=1, jal_sel=1, instr_done=1.
  - The PC still holds PC+4 this cycle, so r31 receives the return address.
  - Next: FETCH.
- JR: pc_src=11, pc_ld=1, instr_done=1. Next: FETCH.
- Cycle counts per instruction:
  - lw: 5.
  - R-type, addi, slti, sw: 4.
  - beq, j, jal, jr: 3.
  - Illegal: 2.
- mem_read and mem_write are never high in the same cycle.
- reg_write and mem_write are never high in the same cycle.
- pc_ld is high in at most one non-FETCH state per instruction.

Test Plan:
- Reset: rst=1 for 2 cycles, then release → first cycle after release shows IorD=0, mem_read=1, IRwrite=1, pc_ld=1, alu_src_B=01; all write strobes 0.
- add, inst_in=32'h01095020 → sequence FETCH, DECODE, R_EX (alu_ctrl=010), R_WB (reg_write=1, reg_dst=1); instr_done high in cycle 4 only.
- lw, inst_in=32'h8D090004 → 5 cycles; MEM_RD has IorD=1, mem_read=1; MEM_WB has mem_to_reg=1, reg_dst=0.
- sw, inst_in=32'hAD090008 → 4 cycles; mem_write=1 and IorD=1 in cycle 4; reg_write stays 0 throughout.
- beq, inst_in=32'h11090003 → with zero=1 in cycle 3: pc_ld=1, pc_src=10, alu_ctrl=110. Repeat with zero=0: pc_ld=0.
- jal, inst_in=32'h0C000010 → cycle 3 has pc_src=01, reg_write=R31_sel=jal_sel=pc_ld=1.
- Illegal opcode 6'b111111 → FETCH, DECODE, FETCH; no reg_write, mem_write, or instr_done.
- rst asserted during MEM_RD → next cycle is FETCH; MEM_WB never occurs.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control unit. A Moore FSM with one state per clock
// drives every datapath control input and the memory strobes. The only
// input-dependent output is pc_ld in BEQ, which follows the ALU zero flag.
// The current state is exported on state_dbg for observation.
module mc_controller #(
  parameter logic [2:0] ALU_AND = 3'b000,
  parameter logic [2:0] ALU_OR  = 3'b001,
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter logic [2:0] ALU_SUB = 3'b110,
  parameter logic [2:0] ALU_SLT = 3'b111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        zero,
  output logic        pc_ld,
  output logic        IorD,
  output logic        IRwrite,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_A,
  output logic [1:0]  alu_src_B,
  output logic [2:0]  alu_ctrl,
  output logic        reg_write,
  output logic [1:0]  pc_src,
  output logic        R31_sel,
  output logic        jal_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        instr_done,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] R_EX    = 4'd2;
  localparam logic [3:0] R_WB    = 4'd3;
  localparam logic [3:0] I_EX    = 4'd4;
  localparam logic [3:0] I_WB    = 4'd5;
  localparam logic [3:0] MEM_ADR = 4'd6;
  localparam logic [3:0] MEM_RD  = 4'd7;
  localparam logic [3:0] MEM_WB  = 4'd8;
  localparam logic [3:0] MEM_WR  = 4'd9;
  localparam logic [3:0] BEQ     = 4'd10;
  localparam logic [3:0] JUMP    = 4'd11;
  localparam logic [3:0] JAL     = 4'd12;
  localparam logic [3:0] JR      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [5:0] opcode;
  logic [5:0] funct;

  // The IR is only reloaded in FETCH, so its fields stay valid for the
  // whole instruction and need no local copy.
  assign opcode    = inst_in[31:26];
  assign funct     = inst_in[5:0];
  assign state_dbg = state;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next-state logic, including the DECODE dispatch on opcode/funct.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_JR:                                  state_nxt = JR;
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  state_nxt = R_EX;
              default:                                state_nxt = FETCH;
            endcase
          end
          OP_LW, OP_SW:     state_nxt = MEM_ADR;
          OP_BEQ:           state_nxt = BEQ;
          OP_ADDI, OP_SLTI: state_nxt = I_EX;
          OP_J:             state_nxt = JUMP;
          OP_JAL:           state_nxt = JAL;
          default:          state_nxt = FETCH;
        endcase
      end
      R_EX:    state_nxt = R_WB;
      I_EX:    state_nxt = I_WB;
      MEM_ADR: state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  state_nxt = MEM_WB;
      default: state_nxt = FETCH;
    endcase
  end

  // Control outputs per state; everything not set is 0, ALU defaults to ADD.
  always_comb begin
    pc_ld      = 1'b0;
    IorD       = 1'b0;
    IRwrite    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_A  = 1'b0;
    alu_src_B  = 2'b00;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    pc_src     = 2'b00;
    R31_sel    = 1'b0;
    jal_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        IRwrite   = 1'b1;
        alu_src_B = 2'b01;
        pc_ld     = 1'b1;
      end
      DECODE: alu_src_B = 2'b11;
      R_EX: begin
        alu_src_A = 1'b1;
        case (funct)
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      I_EX: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
        alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_ADR: begin
        alu_src_A = 1'b1;
        alu_src_B = 2'b10;
      end
      MEM_RD: begin
        IorD     = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        IorD       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      BEQ: begin
        alu_src_A  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b10;
        pc_ld      = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        pc_src     = 2'b01;
        pc_ld      = 1'b1;
        instr_done = 1'b1;
      end
      JAL: begin
        pc_src     = 2'b01;
        pc_ld      = 1'b1;
        reg_write  = 1'b1;
        R31_sel    = 1'b1;
        jal_sel    = 1'b1;
        instr_done = 1'b1;
      end
      JR: begin
        pc_src     = 2'b11;
        pc_ld      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: an instruction-level reference model builds
// the expected per-cycle control word sequence, the driver records what the
// DUT shows each cycle, and each test task compares the two streams.
module tb_mc_controller;

  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;
  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_SLT = 3'b111;
  localparam int W = 19;

  typedef struct packed {
    logic       pc_ld;
    logic       iord;
    logic       irwrite;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic [1:0] pc_src;
    logic       r31_sel;
    logic       jal_sel;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
  } ctl_t;

  logic        clk;
  logic        rst;
  logic [31:0] inst_in;
  logic        zero;
  logic        pc_ld, IorD, IRwrite, reg_dst, mem_to_reg, alu_src_A;
  logic [1:0]  alu_src_B;
  logic [2:0]  alu_ctrl;
  logic        reg_write;
  logic [1:0]  pc_src;
  logic        R31_sel, jal_sel, mem_read, mem_write, instr_done;
  logic [3:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int checks;
  int errors;

  mc_controller dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .zero(zero),
    .pc_ld(pc_ld), .IorD(IorD), .IRwrite(IRwrite), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .pc_src(pc_src),
    .R31_sel(R31_sel), .jal_sel(jal_sel), .mem_read(mem_read),
    .mem_write(mem_write), .instr_done(instr_done), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.alu_ctrl = A_ADD;
    return c;
  endfunction

  function automatic ctl_t fetch_word();
    ctl_t c;
    c = idle();
    c.mem_read = 1'b1;
    c.irwrite = 1'b1;
    c.alu_src_b = 2'b01;
    c.pc_ld = 1'b1;
    return c;
  endfunction

  // Appends the control words one instruction produces; returns its length.
  function automatic int model(input logic [31:0] inst, input logic z);
    ctl_t c;
    logic [5:0] op;
    logic [5:0] fn;
    int n0;
    n0 = exp_q.size();
    op = inst[31:26];
    fn = inst[5:0];
    exp_q.push_back(fetch_word());
    c = idle(); c.alu_src_b = 2'b11;
    exp_q.push_back(c);
    if (op == 6'd0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                       fn == 6'h25 || fn == 6'h2A)) begin
      c = idle(); c.alu_src_a = 1'b1;
      case (fn)
        6'h22:   c.alu_ctrl = A_SUB;
        6'h24:   c.alu_ctrl = A_AND;
        6'h25:   c.alu_ctrl = A_OR;
        6'h2A:   c.alu_ctrl = A_SLT;
        default: c.alu_ctrl = A_ADD;
      endcase
      exp_q.push_back(c);
      c = idle(); c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
      exp_q.push_back(c);
    end else if (op == 6'd0 && fn == 6'h08) begin
      c = idle(); c.pc_src = 2'b11; c.pc_ld = 1'b1; c.instr_done = 1'b1;
      exp_q.push_back(c);
    end else if (op == 6'd35 || op == 6'd43) begin
      c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      exp_q.push_back(c);
      if (op == 6'd35) begin
        c = idle(); c.iord = 1'b1; c.mem_read = 1'b1;
        exp_q.push_back(c);
        c = idle(); c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
        exp_q.push_back(c);
      end else begin
        c = idle(); c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1;
        exp_q.push_back(c);
      end
    end else if (op == 6'd4) begin
      c = idle(); c.alu_src_a = 1'b1; c.alu_ctrl = A_SUB; c.pc_src = 2'b10;
      c.pc_ld = z; c.instr_done = 1'b1;
      exp_q.push_back(c);
    end else if (op == 6'd8 || op == 6'd10) begin
      c = idle(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
      c.alu_ctrl = (op == 6'd10) ? A_SLT : A_ADD;
      exp_q.push_back(c);
      c = idle(); c.reg_write = 1'b1; c.instr_done = 1'b1;
      exp_q.push_back(c);
    end else if (op == 6'd2 || op == 6'd3) begin
      c = idle(); c.pc_src = 2'b01; c.pc_ld = 1'b1; c.instr_done = 1'b1;
      if (op == 6'd3) begin
        c.reg_write = 1'b1; c.r31_sel = 1'b1; c.jal_sel = 1'b1;
      end
      exp_q.push_back(c);
    end
    return exp_q.size() - n0;
  endfunction

  // ---------------- driver ----------------
  function automatic logic [W-1:0] sample();
    return {pc_ld, IorD, IRwrite, reg_dst, mem_to_reg, alu_src_A, alu_src_B,
            alu_ctrl, reg_write, pc_src, R31_sel, jal_sel, mem_read,
            mem_write, instr_done};
  endfunction

  // Holds one instruction for n cycles; rst is raised during cycle rst_at.
  task automatic drive_instr(input logic [31:0] inst, input logic z,
                             input int n, input int rst_at);
    for (int i = 0; i < n; i++) begin
      inst_in = inst;
      zero = z;
      rst = (i == rst_at);
      #1;
      obs_q.push_back(sample());
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  // Models and drives one instruction, then expects FETCH next if last.
  task automatic run(input logic [31:0] inst, input logic z, input bit last);
    int n;
    n = model(inst, z);
    drive_instr(inst, z, n, -1);
    if (last) begin
      exp_q.push_back(fetch_word());
      drive_instr(32'hFC00_0000, 1'b0, 1, -1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] o;
    logic [W-1:0] e;
    inst_in = 32'h01095020;
    zero = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    o = sample();
    e = fetch_word();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL reset_fetch got %h expected %h", o, e);
    end
    checks++;
    if (reg_write !== 1'b0 || mem_write !== 1'b0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got rw=%b mw=%b done=%b expected 0 0 0",
               reg_write, mem_write, instr_done);
    end
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_rtype();
    logic [W-1:0] e;
    logic [W-1:0] o;
    int k;
    do_reset();
    run(32'h01095020, 1'b0, 0);
    run(32'h01095022, 1'b1, 0);
    run(32'h01095024, 1'b0, 0);
    run(32'h01095025, 1'b0, 0);
    run(32'h0109502A, 1'b1, 0);
    run(32'h21280005, 1'b0, 0);
    run(32'h2928FFFF, 1'b1, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rtype_imm cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_mem();
    logic [W-1:0] e;
    logic [W-1:0] o;
    int k;
    do_reset();
    run(32'h8D090004, 1'b0, 0);
    run(32'hAD090008, 1'b1, 0);
    run(32'h8D090004, 1'b1, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lw_sw cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_branch_jump();
    logic [W-1:0] e;
    logic [W-1:0] o;
    int k;
    do_reset();
    run(32'h11090003, 1'b1, 0);
    run(32'h11090003, 1'b0, 0);
    run(32'h08000040, 1'b0, 0);
    run(32'h0C000010, 1'b0, 0);
    run(32'h03E00008, 1'b1, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL beq_jump cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] e;
    logic [W-1:0] o;
    int k;
    do_reset();
    run(32'hFC000000, 1'b0, 0);
    run(32'h01095021, 1'b1, 0);
    run(32'h1D090003, 1'b1, 0);
    run(32'h01095020, 1'b0, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    logic [W-1:0] o;
    logic [W-1:0] drop;
    int n;
    int k;
    do_reset();
    // lw is cut during MEM_RD: its MEM_WB word must never appear.
    n = model(32'h8D090004, 1'b0);
    drop = exp_q.pop_back();
    drive_instr(32'h8D090004, 1'b0, n - 1, n - 2);
    run(32'hAD090008, 1'b0, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
    checks++;
    if (drop === fetch_word()) begin
      errors++;
      $display("FAIL reset_mid_model got %h expected non-fetch word", drop);
    end
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'd0 || op == 6'd2 || op == 6'd3 || op == 6'd4 ||
           op == 6'd8 || op == 6'd10 || op == 6'd35 || op == 6'd43;
  endfunction

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn == 6'h08 || fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
           fn == 6'h25 || fn == 6'h2A;
  endfunction

  task automatic test_random();
    logic [W-1:0] e;
    logic [W-1:0] o;
    logic [31:0] r;
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] rfn[6];
    logic [5:0] iop[8];
    int k;
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
    iop = '{6'd35, 6'd43, 6'd4, 6'd8, 6'd10, 6'd2, 6'd3, 6'd35};
    do_reset();
    for (int t = 0; t < 300; t++) begin
      r = $urandom;
      k = $urandom_range(0, 15);
      if (k < 6) begin
        op = 6'd0;
        fn = rfn[k];
      end else if (k < 14) begin
        op = iop[k - 6];
        fn = r[5:0];
      end else if (k == 14) begin
        op = 6'd0;
        do fn = 6'($urandom); while (legal_fn(fn));
      end else begin
        do op = 6'($urandom); while (legal_op(op));
        fn = r[5:0];
      end
      run({op, r[25:6], fn}, 1'($urandom_range(0, 1)), t == 299);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random cycle %0d got %h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    inst_in = '0;
    zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
